// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner encoding and grant selection for mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

    localparam int WORD_OFS_W = 2;

    function automatic owner_e sel_grant(input logic if_v, input logic d_v, input logic starved);
        return (d_v && !(if_v && starved)) ? OWN_D : (if_v ? OWN_IF : OWN_NONE);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between fetch and data ports,
// data-first with a starvation guard that periodically forces a fetch grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       if_req_valid,
    output logic                       if_req_ready,
    input  logic [ADDR_W-1:0]          if_addr,
    output logic                       if_rsp_valid,
    output logic [DATA_W-1:0]          if_rdata,
    input  logic                       d_req_valid,
    output logic                       d_req_ready,
    input  logic [ADDR_W-1:0]          d_addr,
    input  logic                       d_we,
    input  logic [DATA_W/8-1:0]        d_wstrb,
    input  logic [DATA_W-1:0]          d_wdata,
    output logic                       d_rsp_valid,
    output logic [DATA_W-1:0]          d_rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [DATA_W/8-1:0]        mem_wstrb,
    output logic [ADDR_W-WORD_OFS_W-1:0] mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int CNT_W = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;

    owner_e              owner_q, win;
    logic                we_q, sat, d_streak;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
    logic [ADDR_W-1:0]   sel_addr;

    assign sat          = starve_cnt_q == CNT_W'(STARVE_LIMIT);
    assign win          = reset ? OWN_NONE : sel_grant(if_req_valid, d_req_valid, STARVE_LIMIT != 0 && sat);
    assign d_streak     = win == OWN_D && if_req_valid;
    assign starve_cnt_d = !d_streak ? '0 : sat ? starve_cnt_q : starve_cnt_q + 1'b1;

    assign if_req_ready = win == OWN_IF;
    assign d_req_ready  = win == OWN_D;
    assign sel_addr     = d_req_ready ? d_addr : if_addr;
    assign mem_en       = win != OWN_NONE;
    assign mem_we       = d_req_ready && d_we;
    assign mem_wstrb    = mem_we ? d_wstrb : '0;
    assign mem_addr     = (ADDR_W-WORD_OFS_W)'(sel_addr >> WORD_OFS_W);
    assign mem_wdata    = d_wdata;

    // Responses pass mem_rdata straight through; the _q copies hold it between responses.
    assign if_rsp_valid = !reset && owner_q == OWN_IF;
    assign d_rsp_valid  = !reset && owner_q == OWN_D;
    assign if_rdata     = if_rsp_valid ? mem_rdata : if_rdata_q;
    assign d_rdata      = d_rsp_valid ? (we_q ? '0 : mem_rdata) : d_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_NONE;
            we_q         <= 1'b0;
            starve_cnt_q <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            owner_q      <= win;
            we_q         <= mem_we;
            starve_cnt_q <= starve_cnt_d;
            if_rdata_q   <= if_rdata;
            d_rdata_q    <= d_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a grant/response reference model.
module tb_mem_arbiter;

    localparam int LIM = 4;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    logic        clk, reset;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb, mem_wstrb;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int          checks = 0, errors = 0, cyc = 0, streak = 0, last_win = 0;
    logic        mon_en = 0;
    logic [31:0] nxt_rdata = 0, last_if = 0, last_d = 0;
    rsp_t        q[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; rd is the memory read data presented in the following cycle.
    task automatic step(input logic r, input logic iv, input logic [31:0] ia, input logic dv,
                        input logic [31:0] da, input logic we, input logic [3:0] st,
                        input logic [31:0] wd, input logic [31:0] rd);
        int w;
        @(posedge clk);
        cyc++;
        #1;
        mem_rdata    = nxt_rdata;
        nxt_rdata    = rd;
        reset        = r;
        if_req_valid = iv;
        if_addr      = ia;
        d_req_valid  = dv;
        d_addr       = da;
        d_we         = we;
        d_wstrb      = st;
        d_wdata      = wd;
        #1;
        if (r) begin
            while (q.size() != 0 && q[0].cyc <= cyc) void'(q.pop_front());
            streak = 0;
            w      = 0;
            chk("rst_if_ready", if_req_ready, 0);
            chk("rst_d_ready", d_req_ready, 0);
            chk("rst_mem_en", mem_en, 0);
        end else begin
            w = (dv && !(iv && LIM != 0 && streak == LIM)) ? 2 : iv ? 1 : 0;
            chk("if_req_ready", if_req_ready, w == 1);
            chk("d_req_ready", d_req_ready, w == 2);
            chk("mem_en", mem_en, w != 0);
            chk("mem_we", mem_we, w == 2 && we);
            if (w != 0) begin
                chk("mem_addr", mem_addr, (w == 2 ? da : ia) / 4);
                chk("mem_wstrb", mem_wstrb, (w == 2 && we) ? st : 4'h0);
                if (w == 2) chk("mem_wdata", mem_wdata, wd);
                q.push_back('{w, (w == 2 && we) ? 32'h0 : rd, cyc + 1});
            end
            streak = (w == 2 && iv) ? (streak < LIM ? streak + 1 : streak) : 0;
        end
        last_win = w;
    endtask

    always @(negedge clk) begin
        rsp_t        e;
        logic        ei, ed;
        logic [31:0] edat;
        if (mon_en) begin
            ei   = 0;
            ed   = 0;
            edat = 0;
            if (q.size() != 0 && q[0].cyc == cyc) begin
                e    = q.pop_front();
                ei   = e.port == 1;
                ed   = e.port == 2;
                edat = e.data;
            end
            chk("if_rsp_valid", if_rsp_valid, ei);
            chk("d_rsp_valid", d_rsp_valid, ed);
            chk("if_rdata", if_rdata, ei ? edat : last_if);
            chk("d_rdata", d_rdata, ed ? edat : last_d);
            if (ei) last_if = edat;
            if (ed) last_d = edat;
            if (reset) begin
                last_if = 0;
                last_d  = 0;
            end
        end
    end

    initial begin
        reset = 1; if_req_valid = 0; if_addr = 0; d_req_valid = 0; d_addr = 0;
        d_we = 0; d_wstrb = 0; d_wdata = 0; mem_rdata = 0;
        step(1, 1, 32'h40, 1, 32'h80, 0, 0, 0, 0);
        step(1, 1, 32'h40, 1, 32'h80, 0, 0, 0, 0);
        mon_en = 1;
        step(0, 1, 32'h10, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h20, 1, 4'b0011, 32'h1234, 32'hCAFEF00D);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 32'h100 + 4 * i, 1, 32'h200 + 4 * i, 0, 0, 0, $urandom);
            chk("starve_seq", last_win, (i % 5 == 4) ? 1 : 2);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step(0, i % 2 == 0, 32'h300 + 4 * i, i % 2 == 1, 32'h400 + 4 * i, 0, 0, 0, $urandom);
        step(0, 0, 0, 1, 32'h44, 0, 0, 0, 32'h55AA55AA);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h48, 0, 0, 0, 32'h0BADCAFE);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, $urandom,
                 $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1,
                 4'($urandom), $urandom, $urandom);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and data load/store port.
- Fixed priority: data over fetch, with a starvation guard that forces a fetch grant after STARVE_LIMIT consecutive data wins.
- Sits between the core's pipeline control and the unified memory instance.
- One access issued per cycle; response exactly one cycle after acceptance.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; must be a multiple of 8.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending; 0 disables the guard.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  ADDR_W  fetch address.
- if_rsp_valid  out  1  fetch response pulse.
- if_rdata  out  DATA_W  fetch read data.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted this cycle.
- d_addr  in  ADDR_W  data address.
- d_we  in  1  1 = store, 0 = load.
- d_wstrb  in  DATA_W/8  byte strobes (stores only).
- d_wdata  in  DATA_W  store data.
- d_rsp_valid  out  1  data response pulse (loads and stores).
- d_rdata  out  DATA_W  load data; 0 for stores.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_wstrb  out  DATA_W/8  memory byte strobes.
- mem_addr  out  ADDR_W-2  word address (byte address >> 2).
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Single clock, clk. reset is synchronous and active-high.
- Reset values:
  - if_rsp_valid, d_rsp_valid = 0.
  - owner = OWN_NONE.
  - starve_cnt = 0.
  - if_rdata, d_rdata = 0.
- Grant logic (combinational from current inputs and starve_cnt):
  - Only d_req_valid set → data wins.
  - Only if_req_valid set → fetch wins.
  - Both set → data wins unless STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT; then fetch wins.
  - Winner's *_req_ready = 1 in that cycle; loser's ready = 0.
  - ready is never asserted without the matching valid.
  - ready = 0 for both ports while reset is high.
- Memory drive in the accept cycle:
  - mem_en = 1.
  - mem_addr = winner addr[ADDR_W-1:2].
  - For data: mem_we = d_we, mem_wstrb = d_wstrb if d_we else 0, mem_wdata = d_wdata.
  - For fetch: mem_we = 0, mem_wstrb = 0.
  - No accept → mem_en = 0 and mem_we = 0.
- Owner register: owner <= winner, or OWN_NONE if nothing was accepted. A write-flag register records whether the data access was a store.
- Response in the cycle after acceptance:
  - owner == OWN_IF → if_rsp_valid = 1, if_rdata = mem_rdata.
  - owner == OWN_D → d_rsp_valid = 1; d_rdata = mem_rdata for loads, 0 for stores.
  - Response valids are single-cycle pulses with no back-pressure; requesters must always sink responses.
- Back-to-back accepts are allowed. Latency is exactly 1 cycle and responses return in acceptance order.
- starve_cnt (width covers STARVE_LIMIT):
  - Increments when data wins while if_req_valid = 1.
  - Clears when fetch is granted or if_req_valid = 0.
  - Saturates at STARVE_LIMIT.
- Reset asserted mid-operation: the outstanding response is dropped, so no rsp_valid in the cycle after reset. owner clears.
- Misaligned address (addr[1:0] != 0): low bits are ignored, with no error signalling. Alignment is the core's responsibility.
- Response data registers hold their value when no response is issued.

Decomposition:
- Package mem_arb_pkg:
  - owner_e enum {OWN_NONE, OWN_IF, OWN_D}.
  - Constant WORD_OFS_W = 2.
- Grant selection is a function in the package.
- No sub-module; single flat module.

Test Plan:
- Reset held for 2 cycles with both requests valid → both ready = 0, mem_en = 0; both rsp_valid = 0 in the cycle after reset release.
- Fetch-only request if_addr=0x10 with mem_rdata=0xDEADBEEF → if_req_ready = 1 the same cycle, mem_addr = 0x4; next cycle if_rsp_valid = 1, if_rdata = 0xDEADBEEF.
- Store d_addr=0x20, d_wstrb=4'b0011, d_wdata=0x1234 → mem_we = 1, mem_wstrb = 4'b0011, mem_addr = 0x8; next cycle d_rsp_valid = 1, d_rdata = 0.
- Both valid continuously, STARVE_LIMIT=4 → grant sequence D,D,D,D,IF,D,D,D,D,IF; one response per cycle.
- Alternating fetch/load requests on consecutive cycles → responses arrive 1 cycle after each accept on the correct port, with no gaps.
- Reset asserted the cycle after a load is accepted → d_rsp_valid stays 0; after release, a new load completes normally.
